// File: rtl/ecc_decode_feeder_if.sv
// ============================================================================
//  Module      : ecc_decode_feeder_if
//  Description : Byte-stream input and word-write output bundle of the ECC
//                decode feeder.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

interface ecc_decode_feeder_if;
    logic [7:0]  nand_byte;
    logic        nand_byte_vld;
    logic        nand_byte_rdy;
    logic        ecc_decode_rdy;
    logic        decode_output_over;
    logic        ecc_decode_req;
    logic        wr_en;
    logic [31:0] data_out;

    modport master (
        input  nand_byte,
        input  nand_byte_vld,
        input  ecc_decode_rdy,
        input  decode_output_over,
        output nand_byte_rdy,
        output ecc_decode_req,
        output wr_en,
        output data_out
    );

    modport slave (
        output nand_byte,
        output nand_byte_vld,
        output ecc_decode_rdy,
        output decode_output_over,
        input  nand_byte_rdy,
        input  ecc_decode_req,
        input  wr_en,
        input  data_out
    );
endinterface

`default_nettype wire

// File: rtl/ecc_decode_feeder.sv
// ============================================================================
//  Module      : ecc_decode_feeder
//  Description : Packs one NAND codeword byte stream into 32-bit words and
//                feeds the ECC decode controller. Optional erased-page
//                detection is enabled by ECC_ERASED_PAGE_DETECT_EN.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module ecc_decode_feeder #(
    parameter int CW_WORDS   = 288,
    parameter int CW_BYTES   = CW_WORDS * 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       abort,
    ecc_decode_feeder_if.master        bus,
    output logic                       busy,
    output logic                       cw_done,
    output logic                       erased_page
);

    localparam int c_AW   = $clog2(FIFO_DEPTH);
    localparam int c_CNTW = $clog2(FIFO_DEPTH + 1);
    localparam int c_BW   = $clog2(CW_BYTES + 1);
    localparam int c_WW   = $clog2(CW_WORDS + 1);

    localparam logic [c_BW-1:0]   c_CW_BYTES  = c_BW'(CW_BYTES);
    localparam logic [c_WW-1:0]   c_CW_WORDS  = c_WW'(CW_WORDS);
    localparam logic [c_CNTW-1:0] c_FIFO_FULL = c_CNTW'(FIFO_DEPTH);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_FILL     = 2'd1;
    localparam logic [1:0] c_WAIT_DEC = 2'd2;
    localparam logic [1:0] c_DONE     = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [c_BW-1:0]   r_bytes_in;
    logic [c_WW-1:0]   r_words_out;
    logic [31:0]       r_pack;
    logic [31:0]       r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_CNTW-1:0] r_count;
    logic              r_wr_en;
    logic [31:0]       r_data_out;

    logic              w_in_fill;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic              w_byte_rdy;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic              w_start;
    logic              w_to_wait;
    logic [31:0]       w_word;

    assign w_in_fill    = (r_state == c_FILL);
    assign w_fifo_full  = (r_count == c_FIFO_FULL);
    assign w_fifo_empty = (r_count == '0);
    assign w_byte_rdy   = w_in_fill && (r_bytes_in < c_CW_BYTES) && !w_fifo_full;
    assign w_accept     = w_byte_rdy && bus.nand_byte_vld;
    assign w_push       = w_accept && (r_bytes_in[1:0] == 2'd3);
    // The word-count guard keeps a stray FIFO entry from ever becoming word 289.
    assign w_pop        = w_in_fill && !w_fifo_empty && bus.ecc_decode_rdy
                          && (r_words_out < c_CW_WORDS);
    assign w_start      = (r_state == c_IDLE) && start && !abort;
    assign w_to_wait    = w_in_fill && (r_words_out == c_CW_WORDS) && !abort;
    assign w_word       = {bus.nand_byte, r_pack[23:0]};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:     if (start) w_state_nxt = c_FILL;
            c_FILL:     if (r_words_out == c_CW_WORDS) w_state_nxt = c_WAIT_DEC;
            c_WAIT_DEC: if (bus.decode_output_over) w_state_nxt = c_DONE;
            c_DONE:     w_state_nxt = c_IDLE;
            default:    w_state_nxt = c_IDLE;
        endcase
        if (abort) begin
            w_state_nxt = c_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bytes_in  <= '0;
            r_words_out <= '0;
            r_pack      <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_wr_en     <= 1'b0;
            r_data_out  <= '0;
        end else if (abort || w_start) begin
            r_bytes_in  <= '0;
            r_words_out <= '0;
            r_pack      <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_wr_en     <= 1'b0;
            r_data_out  <= '0;
        end else begin
            r_wr_en <= w_pop;
            if (w_accept) begin
                r_pack[{r_bytes_in[1:0], 3'b000} +: 8] <= bus.nand_byte;
                r_bytes_in <= r_bytes_in + 1'b1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr    <= r_rd_ptr + 1'b1;
                r_data_out  <= r_mem[r_rd_ptr];
                r_words_out <= r_words_out + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read while the count says valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

`ifdef ECC_ERASED_PAGE_DETECT_EN
    logic r_all_ff;
    logic r_erased;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_all_ff <= 1'b0;
            r_erased <= 1'b0;
        end else if (abort) begin
            r_all_ff <= 1'b0;
            r_erased <= 1'b0;
        end else if (w_start) begin
            r_all_ff <= 1'b1;
            r_erased <= 1'b0;
        end else begin
            if (w_accept && (bus.nand_byte != 8'hFF)) begin
                r_all_ff <= 1'b0;
            end
            if (w_to_wait) begin
                r_erased <= r_all_ff;
            end
        end
    end

    assign erased_page = r_erased;
`else
    assign erased_page = 1'b0;
`endif

    assign bus.nand_byte_rdy  = w_byte_rdy;
    assign bus.ecc_decode_req = (r_state == c_FILL) || (r_state == c_WAIT_DEC);
    assign bus.wr_en          = r_wr_en;
    assign bus.data_out       = r_data_out;
    assign busy               = (r_state != c_IDLE);
    assign cw_done            = (r_state == c_DONE);

endmodule

`default_nettype wire

// File: tb/tb_ecc_decode_feeder.sv
// ============================================================================
//  Module      : tb_ecc_decode_feeder
//  Description : Randomized self-checking bench for ecc_decode_feeder with a
//                phase-level reference model and per-cycle output compare.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_ecc_decode_feeder;

    localparam int CW_WORDS = 288;
    localparam int CW_BYTES = 1152;
    localparam int P_IDLE = 0, P_FILL = 1, P_WAIT = 2, P_DONE = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic busy, cw_done, erased_page;

    ecc_decode_feeder_if bus ();

    ecc_decode_feeder #(
        .CW_WORDS  (CW_WORDS),
        .CW_BYTES  (CW_BYTES),
        .FIFO_DEPTH(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .bus        (bus),
        .busy       (busy),
        .cw_done    (cw_done),
        .erased_page(erased_page)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  cw  [CW_BYTES];
    logic [31:0] got [CW_WORDS];

    // Reference model state, owned by the monitor
    int ph = P_IDLE;
    int nbytes = 0, nwords = 0, ndone = 0, cyc = 0;
    bit all_ff = 1'b0, exp_erased = 1'b0;
    int first_acc = -1, first_wr = -1, last_wr = -1;
    int min_gap = 1000000, max_gap = 0, max_occ = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        int occ, nph, gap;
        bit exp_rdy, ee;
        logic [31:0] expw;
        cyc++;
        if (!rst_n) begin
            check("reset_outs", {27'd0, busy, bus.ecc_decode_req, cw_done, bus.nand_byte_rdy,
                                 bus.wr_en}, 32'd0);
            check("reset_data", bus.data_out, 32'd0);
            check("reset_erased", {31'd0, erased_page}, 32'd0);
            ph = P_IDLE; nbytes = 0; nwords = 0; exp_erased = 1'b0;
        end else begin
            // Words still buffered = words completed by the source minus words handed over
            occ = nbytes / 4 - nwords - (bus.wr_en ? 1 : 0);
            if (occ > max_occ) max_occ = occ;
            exp_rdy = (ph == P_FILL) && (nbytes < CW_BYTES) && (occ < 4);
`ifdef ECC_ERASED_PAGE_DETECT_EN
            ee = exp_erased;
`else
            ee = 1'b0;
`endif
            check("ctrl{busy,req,done,rdy,erased}",
                  {27'd0, busy, bus.ecc_decode_req, cw_done, bus.nand_byte_rdy, erased_page},
                  {27'd0, ph != P_IDLE, (ph == P_FILL) || (ph == P_WAIT), ph == P_DONE, exp_rdy, ee});
            nph = ph;
            if (bus.wr_en) begin
                check("wr_en_legal", {31'd0, (ph == P_FILL) && (nwords < CW_WORDS)}, 32'd1);
                if (nwords < CW_WORDS) begin
                    expw = {cw[4*nwords+3], cw[4*nwords+2], cw[4*nwords+1], cw[4*nwords]};
                    check("word", bus.data_out, expw);
                    got[nwords] = bus.data_out;
                end
                if (last_wr >= 0) begin
                    gap = cyc - last_wr;
                    if (gap < min_gap) min_gap = gap;
                    if (gap > max_gap) max_gap = gap;
                end else begin
                    first_wr = cyc;
                end
                last_wr = cyc;
                nwords++;
                if (ph == P_FILL && nwords == CW_WORDS) nph = P_WAIT;
            end
            if (bus.nand_byte_vld && bus.nand_byte_rdy) begin
                if (first_acc < 0) first_acc = cyc;
                if (bus.nand_byte != 8'hFF) all_ff = 1'b0;
                nbytes++;
            end
            if (ph == P_WAIT && bus.decode_output_over) nph = P_DONE;
            if (ph == P_DONE) begin
                check("words_per_cw", nwords, CW_WORDS);
                ndone++;
                nph = P_IDLE;
            end
            if (ph == P_IDLE && start) begin
                nph = P_FILL; nbytes = 0; nwords = 0; all_ff = 1'b1; exp_erased = 1'b0;
                first_acc = -1; first_wr = -1; last_wr = -1;
                min_gap = 1000000; max_gap = 0; max_occ = 0;
            end
            if (ph == P_FILL && nph == P_WAIT) exp_erased = all_ff;
            if (abort) begin
                nph = P_IDLE; nbytes = 0; nwords = 0; exp_erased = 1'b0;
            end
            ph = nph;
        end
    end

    // vmode: 0 continuous, 1 toggling, 2 random; rmode: 0 ready, 1 random ready
    task automatic run_cw(input int vmode, input int rmode, input int stall_at, input int stall_len,
                          input int abort_words, input int reset_words, input bit start_in_wait);
        int idx, c, wcnt, dly, done0;
        bit acc, completed;
        idx = 0; c = 0; wcnt = 0; completed = 1'b0;
        done0 = ndone;
        dly = $urandom_range(1, 6);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (c < 8000) begin
            if (abort_words >= 0 && nwords >= abort_words && ph == P_FILL) begin
                abort = 1'b1;
                bus.nand_byte_vld = 1'b0;
                @(posedge clk); #1;
                abort = 1'b0;
                check("abort_req", {31'd0, bus.ecc_decode_req}, 32'd0);
                check("abort_busy", {31'd0, busy}, 32'd0);
                check("abort_wr_en", {31'd0, bus.wr_en}, 32'd0);
                return;
            end
            if (reset_words >= 0 && nwords >= reset_words) begin
                #2 rst_n = 1'b0;
                #1;
                check("async_rst_outs", {26'd0, busy, bus.ecc_decode_req, cw_done, bus.nand_byte_rdy,
                                         bus.wr_en, erased_page}, 32'd0);
                check("async_rst_data", bus.data_out, 32'd0);
                bus.nand_byte_vld = 1'b0;
                @(posedge clk); @(posedge clk); #1;
                rst_n = 1'b1;
                return;
            end
            case (vmode)
                0:       bus.nand_byte_vld = 1'b1;
                1:       bus.nand_byte_vld = (c % 2 == 0);
                default: bus.nand_byte_vld = ($urandom_range(0, 3) != 0);
            endcase
            bus.nand_byte = cw[(idx < CW_BYTES) ? idx : CW_BYTES - 1];
            bus.ecc_decode_rdy = (rmode == 1) ? ($urandom_range(0, 9) < 7) : 1'b1;
            if (c >= stall_at && c < stall_at + stall_len) bus.ecc_decode_rdy = 1'b0;
            bus.decode_output_over = 1'b0;
            start = 1'b0;
            if (ph == P_WAIT) begin
                if (start_in_wait && wcnt == 0) start = 1'b1;
                if (wcnt == dly) bus.decode_output_over = 1'b1;
                wcnt++;
            end
            @(negedge clk);
            acc = bus.nand_byte_vld && bus.nand_byte_rdy;
            @(posedge clk); #1;
            if (acc) idx++;
            c++;
            if (ndone != done0) begin
                completed = 1'b1;
                break;
            end
        end
        bus.nand_byte_vld = 1'b0;
        bus.decode_output_over = 1'b0;
        bus.ecc_decode_rdy = 1'b1;
        start = 1'b0;
        check("cw_completed", {31'd0, completed}, 32'd1);
    endtask

    task automatic fill_random();
        for (int k = 0; k < CW_BYTES; k++) cw[k] = 8'($urandom);
    endtask

    initial begin
        logic [31:0] w0;
        bus.nand_byte = 8'd0;
        bus.nand_byte_vld = 1'b0;
        bus.ecc_decode_rdy = 1'b1;
        bus.decode_output_over = 1'b0;

        // Reset state
        #2;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_req", {31'd0, bus.ecc_decode_req}, 32'd0);
        check("rst_wr_en", {31'd0, bus.wr_en}, 32'd0);
        check("rst_data_out", bus.data_out, 32'd0);
        check("rst_cw_done", {31'd0, cw_done}, 32'd0);
        check("rst_byte_rdy", {31'd0, bus.nand_byte_rdy}, 32'd0);
        check("rst_erased", {31'd0, erased_page}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Nominal incrementing stream
        for (int k = 0; k < CW_BYTES; k++) cw[k] = 8'(k);
        run_cw(0, 0, -1, 0, -1, -1, 1'b0);
        check("nom_word0", got[0], 32'h03020100);
        check("nom_word255", got[255], 32'hFFFEFDFC);
        check("nom_word287", got[287], 32'h7F7E7D7C);
        check("nom_min_gap", min_gap, 4);
        check("nom_max_gap", max_gap, 4);
        check("nom_latency_ge4", {31'd0, (first_wr - first_acc) >= 4}, 32'd1);
        @(posedge clk); #1;
        check("nom_idle_busy", {31'd0, busy}, 32'd0);

        // Backpressure stall mid-FILL
        fill_random();
        run_cw(0, 0, 300, 40, -1, -1, 1'b0);
        check("stall_max_occ", max_occ, 4);

        // Bursty source
        fill_random();
        run_cw(1, 0, -1, 0, -1, -1, 1'b0);
        check("burst_gap_ge8", {31'd0, min_gap >= 8}, 32'd1);

        // Abort then a fresh codeword
        fill_random();
        run_cw(2, 1, -1, 0, 100, -1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        fill_random();
        w0 = {cw[3], cw[2], cw[1], cw[0]};
        run_cw(0, 0, -1, 0, -1, -1, 1'b0);
        check("post_abort_word0", got[0], w0);

        // Start during WAIT_DEC is ignored
        fill_random();
        run_cw(2, 1, -1, 0, -1, -1, 1'b1);

        // Reset mid-FILL, then a full codeword
        fill_random();
        run_cw(0, 1, -1, 0, -1, 50, 1'b0);
        fill_random();
        run_cw(2, 1, -1, 0, -1, -1, 1'b0);

        // Random traffic
        for (int r = 0; r < 2; r++) begin
            fill_random();
            run_cw(2, 1, 200, $urandom_range(5, 60), -1, -1, 1'b0);
        end

`ifdef ECC_ERASED_PAGE_DETECT_EN
        for (int k = 0; k < CW_BYTES; k++) cw[k] = 8'hFF;
        run_cw(0, 0, -1, 0, -1, -1, 1'b0);
        check("erased_all_ff", {31'd0, erased_page}, 32'd1);
        cw[700] = 8'hFE;
        run_cw(2, 1, -1, 0, -1, -1, 1'b0);
        check("erased_one_fe", {31'd0, erased_page}, 32'd0);
`endif

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ecc_decode_feeder.md
Name: ecc_decode_feeder

Overview:
- Upstream stage of the ECC decode path.
- Accepts one NAND codeword as a byte stream from the flash read datapath: 1152 bytes, i.e. 1024 data bytes followed by 128 parity bytes.
- Packs the bytes little-endian into 32-bit words, buffers them in a small FIFO and drives the decode controller's word-write interface (ecc_decode_req / wr_en / data_in).
- Holds the request until the controller reports decode_output_over, then pulses codeword completion back to the flash read sequencer.

Parameters:
- CW_WORDS, 288, 32-bit words per codeword (N/32).
- CW_BYTES, 1152, bytes per codeword (CW_WORDS*4).
- FIFO_DEPTH, 4, word FIFO depth; power of two, minimum 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle pulse; begin one codeword; ignored unless IDLE.
- abort  in  1  synchronous flush to IDLE, any state.
- nand_byte  in  8  read byte from flash datapath.
- nand_byte_vld  in  1  nand_byte valid.
- nand_byte_rdy  out  1  byte accepted when vld&&rdy.
- ecc_decode_rdy  in  1  controller ready; a word is sent only while high.
- decode_output_over  in  1  controller finished outputting decoded data.
- ecc_decode_req  out  1  level request to controller, held FILL..WAIT_DEC.
- wr_en  out  1  word strobe to controller; one word per high cycle.
- data_out  out  32  word to controller data_in; valid when wr_en.
- busy  out  1  state != IDLE.
- cw_done  out  1  one-cycle pulse, codeword fully decoded and drained.
- erased_page  out  1  see Optional Feature; constant 0 when compiled out.

Behaviour:
- Reset values:
  - All outputs 0: nand_byte_rdy, ecc_decode_req, wr_en, data_out, busy, cw_done, erased_page.
  - State IDLE, FIFO empty, lane/byte/word counters 0.
- States: IDLE, FILL, WAIT_DEC, DONE.
- IDLE -> FILL on start. Counters are cleared on entry.
- FILL:
  - ecc_decode_req=1.
  - nand_byte_rdy = (bytes_in < CW_BYTES) && !fifo_full; registered-free, combinational from state/counters.
  - Packing: each accepted byte is written into pack register lane bytes_in[1:0]. Lane 0 is bits [7:0], lane 3 is bits [31:24].
  - On acceptance of lane 3, the completed word is pushed to the FIFO in the same cycle.
  - Pop: wr_en = FILL && !fifo_empty && ecc_decode_rdy (registered output). data_out is the FIFO head, registered with wr_en. words_out increments on every wr_en.
  - Simultaneous push and pop in one cycle is legal; occupancy is unchanged.
  - FILL -> WAIT_DEC in the cycle after the wr_en that carries word CW_WORDS-1 (words_out reaches 288). Byte 1151 is always accepted before this.
  - A word must never be issued after words_out==288.
- WAIT_DEC:
  - ecc_decode_req=1, wr_en=0, nand_byte_rdy=0.
  - Transition to DONE on decode_output_over==1.
- DONE: lasts one cycle. cw_done=1, ecc_decode_req=0. Next state IDLE.
- Stall: ecc_decode_rdy low in FILL freezes popping. The FIFO fills and nand_byte_rdy drops. No data loss and no reordering.
- abort: in any state, next cycle is IDLE. FIFO, pack register and counters are cleared; req=0, wr_en=0, cw_done is not pulsed. abort wins over start in the same cycle.
- start while busy is ignored with no side effects.
- Reset mid-operation returns immediately to reset values; no partial word is retained.
- Latency: first byte accepted at cycle t gives the first wr_en at t+4 or later. With continuous vld and rdy, the word rate is 1 per 4 cycles.

Optional Feature:
- Macro ECC_ERASED_PAGE_DETECT_EN.
- When defined:
  - An all-ones tracker is cleared on start and ANDed with (nand_byte==8'hFF) for each accepted byte.
  - On entry to WAIT_DEC, erased_page = tracker. It is held until the next start, abort or reset.
  - Decode handshake is unchanged; the upstream sequencer decides whether to discard.
- When undefined: erased_page is tied to 0 and no tracker logic is present.

Test Plan:
- Nominal: start; bytes k=0..1151 with nand_byte=k[7:0], vld always 1, ecc_decode_rdy=1 -> exactly 288 wr_en pulses. Word0=32'h03020100, word255=32'hFFFEFDFC, word287=32'h7F7E7D7C. req held, then decode_output_over pulse -> cw_done one cycle later, busy=0.
- Backpressure: ecc_decode_rdy low for 40 cycles mid-FILL -> FIFO reaches 4 entries, nand_byte_rdy=0 during stall, and the word sequence is still exactly 288 in order with no duplicates.
- Bursty source: vld toggling 1/0 every cycle -> packing correct; wr_en spacing ≥8 cycles; 288 words.
- Abort: abort at words_out=100 -> next cycle IDLE, req=0, no cw_done. A following start plus a full codeword yields 288 clean words with word0 from the new stream.
- Reset/ignore: start asserted during WAIT_DEC -> ignored; rst_n low mid-FILL -> all outputs 0 asynchronously.
- ECC_ERASED_PAGE_DETECT_EN: all 1152 bytes 8'hFF -> erased_page=1 at WAIT_DEC; same stream with byte 700=8'hFE -> erased_page=0.
